// File: rtl/cpu_muldiv_seq_if.sv
// Request/response bundle between the matiz decoder and the RV32M mul/div sequencer.
// The CPU side drives requests and flush; the sequencer returns results and status.
interface cpu_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport master (
        output in_valid, in_funct3, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_funct3, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/cpu_muldiv_seq.sv
// RV32M multi-cycle sequencer: 32-step shift-add multiply / restoring divide on
// operand magnitudes, with sign fix-up and fixed results for div-by-zero and overflow.
module cpu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    cpu_muldiv_seq_if.slave    bus
);
    localparam int unsigned W  = XLEN;
    localparam int unsigned W1 = W + 1;
    localparam int unsigned W2 = 2 * W;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [2:0]     funct3_q;
    logic           neg_q;
    logic [W-1:0]   b_mag_q;
    logic [W-1:0]   acc;      // product hi / division remainder
    logic [W-1:0]   lo;       // product lo / division quotient
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;
    logic [W-1:0]   out_result_q;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.out_result = out_result_q;

    // Accept-time decode: operand magnitudes, result sign, special cases
    logic           a_signed_c, b_signed_c, a_neg_c, b_neg_c, res_neg_c;
    logic [W-1:0]   a_mag_c, b_mag_c, special_res_c;
    logic           is_div_c, div_zero_c, overflow_c;

    always_comb begin
        a_signed_c    = 1'b0;
        b_signed_c    = 1'b0;
        a_neg_c       = 1'b0;
        b_neg_c       = 1'b0;
        res_neg_c     = 1'b0;
        a_mag_c       = bus.in_a;
        b_mag_c       = bus.in_b;
        special_res_c = '0;
        is_div_c      = bus.in_funct3[2];

        a_signed_c = (bus.in_funct3 == F_MULH) || (bus.in_funct3 == F_MULHSU) ||
                     (bus.in_funct3 == F_DIV)  || (bus.in_funct3 == F_REM);
        b_signed_c = (bus.in_funct3 == F_MULH) || (bus.in_funct3 == F_DIV) ||
                     (bus.in_funct3 == F_REM);
        a_neg_c = a_signed_c && bus.in_a[W-1];
        b_neg_c = b_signed_c && bus.in_b[W-1];
        if (a_neg_c) a_mag_c = W'(0) - bus.in_a;
        if (b_neg_c) b_mag_c = W'(0) - bus.in_b;

        // Remainder follows the dividend; everything else is the xor of signs
        if (is_div_c && bus.in_funct3[1]) res_neg_c = a_neg_c;
        else                              res_neg_c = a_neg_c ^ b_neg_c;

        div_zero_c = is_div_c && (bus.in_b == '0);
        overflow_c = is_div_c && !bus.in_funct3[0] &&
                     (bus.in_a == INT_MIN) && (bus.in_b == '1);

        if (div_zero_c)      special_res_c = bus.in_funct3[1] ? bus.in_a : '1;
        else if (overflow_c) special_res_c = bus.in_funct3[1] ? '0 : INT_MIN;
    end

    // One iteration step of each datapath
    logic [W1-1:0]  mul_sum_c, div_shift_c, div_sub_c;
    logic           div_ge_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc} + (lo[0] ? {1'b0, b_mag_q} : W1'(0));
        div_shift_c = {acc, lo[W-1]};
        div_sub_c   = div_shift_c - {1'b0, b_mag_q};
        div_ge_c    = div_shift_c >= {1'b0, b_mag_q};
    end

    // Sign fix-up and result selection
    logic [W2-1:0]  prod_c;
    logic [W-1:0]   fix_res_c;

    always_comb begin
        prod_c    = {acc, lo};
        fix_res_c = '0;
        if (neg_q) prod_c = W2'(0) - prod_c;
        if (funct3_q[2]) begin
            if (funct3_q[1]) fix_res_c = neg_q ? W'(0) - acc : acc;
            else             fix_res_c = neg_q ? W'(0) - lo  : lo;
        end else begin
            fix_res_c = (funct3_q == F_MUL) ? prod_c[W-1:0] : prod_c[W2-1:W];
        end
    end

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            funct3_q     <= '0;
            neg_q        <= 1'b0;
            b_mag_q      <= '0;
            acc          <= '0;
            lo           <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
        end else if (bus.flush) begin
            state       <= S_IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        funct3_q   <= bus.in_funct3;
                        neg_q      <= res_neg_c;
                        b_mag_q    <= b_mag_c;
                        in_ready_q <= 1'b0;
                        if (div_zero_c || overflow_c) begin
                            out_result_q <= special_res_c;
                            out_valid_q  <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            acc    <= '0;
                            lo     <= a_mag_c;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (funct3_q[2]) begin
                        acc <= div_ge_c ? div_sub_c[W-1:0] : div_shift_c[W-1:0];
                        lo  <= {lo[W-2:0], div_ge_c};
                    end else begin
                        acc <= mul_sum_c[W:1];
                        lo  <= {mul_sum_c[0], lo[W-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
                S_FIX: begin
                    out_result_q <= fix_res_c;
                    out_valid_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/cpu_muldiv_seq.md
# cpu_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide extension in the matiz CPU. It sits beside the single-cycle ALU and its decoder. The decoder routes instructions with funct7 = 7'b0000001 here instead of to the ALU. The block accepts one operation over a valid/ready handshake, iterates a 32-step shift-add multiply or restoring divide, and applies sign fix-up. It returns the 32-bit result over a second valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- in_funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  input  32  rs1 operand.
- in_b  input  32  rs2 operand.
- flush  input  1  pipeline kill; discards any operation in flight.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_result  output  32  result; value is don't-care while out_valid is low.
- busy  output  1  high in BUSY or FIX.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE, on in_valid: the accept happens. The block latches funct3 and computes operand magnitudes.
  - Signed operands are a for MULH/MULHSU/DIV/REM and b for MULH/DIV/REM; the magnitude of a signed operand is its two's-complement absolute value.
  - The result sign is latched at the same time.
- IDLE, special cases, which go straight to DONE with a fixed result and no iteration:
  - Divide by zero (b = 0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- IDLE, all other accepts: go to BUSY with a 5-bit step counter set to 0.
- BUSY, multiply:
  - The datapath is a 64-bit product register {hi, lo}; lo starts as |a| and hi starts as 0.
  - Each step: if lo[0], hi += |b| with the carry kept in a 33-bit add; then {carry, hi, lo} shifts right by 1.
- BUSY, divide:
  - Restoring divide: remainder register R (33 bits) starts at 0; quotient Q starts as |a|.
  - Each step: {R, Q} shifts left by 1; if R >= |b| then R -= |b| and Q[0] = 1.
- BUSY ends after 32 steps (counter reaches 31) and goes to FIX.
- FIX selects the result: MUL gives lo; MULH/MULHSU/MULHU give hi; DIV/DIVU give Q; REM/REMU give R[31:0].
  - For a negative product, the full 64-bit value is negated before selection.
  - A negative quotient negates Q; the remainder takes the sign of a.
  - FIX then goes to DONE.
- DONE: out_valid = 1 and out_result is held stable until out_valid && out_ready, then the block goes to IDLE.
- flush in any state: next state is IDLE and out_valid drops. flush has priority over in_valid, so an accept in the same cycle is discarded.
- rst in any state, including mid-iteration, gives the same effect as flush.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, busy = 0, out_result = 0, counter = 0.
- in_ready is purely a function of state (IDLE), not of in_valid.
- Normal latency, with the accept at edge E0:
  - BUSY occupies cycles E0+1 … E0+32.
  - FIX occupies the cycle after E0+32.
  - out_valid is high from the cycle after E0+33.
  - The result is therefore available 34 cycles after accept.
- Special-case latency: out_valid is high in the cycle after the accept edge.
- Throughput: a new accept is possible no earlier than the cycle after the out handshake. There is no back-to-back accept in the handshake cycle itself.
- out_ready held low: DONE persists indefinitely with out_result unchanged.
- out_ready has no effect outside DONE.
- busy is a registered output aligned with state.

## Test plan
- MUL 7 × 6 (funct3 0): in_ready drops; out_result = 0x0000002A, out_valid 34 cycles after accept.
- MULH/MULHSU/MULHU with a = b = 0xFFFFFFFF:
  - MULH gives 0x00000000.
  - MULHSU gives 0xFFFFFFFF.
  - MULHU gives 0xFFFFFFFE.
  - MUL gives 0x00000001.
- DIV −7 / 2 and REM −7 / 2: quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIVU 100 / 7 gives 14; REMU gives 2.
- Special cases, each with out_valid one cycle after accept:
  - DIVU 5 / 0 gives 0xFFFFFFFF; REM 5 / 0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid. out_result stays stable and in_ready stays 0; after out_ready = 1, IDLE follows in the next cycle.
- Flush and reset, using MUL 3 × 3 as the aborted operation:
  - Assert flush at BUSY step 10: the next cycle is IDLE with in_ready = 1 and no out_valid.
  - A new MUL 3 × 3 then yields 9.
  - Repeat with rst mid-iteration: same result.
  - flush in the same cycle as in_valid: no accept occurs.
